mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit holding the HI/LO register pair for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU over WIDTH+2 clock edges behind a start/busy/done handshake, and it supports direct HI/LO writes for MTHI/MTLO. It sits beside the ALU. The controller stalls in a wait state until `done` goes high. HI/LO read data feeds the write-back mux.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_step.sv | 43 ++++
 rtl/mdu_iter.sv | 151 +++++++++++++++
 tb/tb_mdu_iter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and sizing helpers for mdu_iter.
// The divider is built only when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add multiply or restoring divide iteration.
// Divide hardware is present only when MDU_DIV_EN is defined.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               qbit
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opnd} : '0);

`ifdef MDU_DIV_EN
  logic [WIDTH:0] rem;
  logic [WIDTH:0] dif;

  // Upper half is the partial remainder, lower half shifts dividend out
  // and quotient bits in.
  assign rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dif  = rem - {1'b0, opnd};
  assign qbit = div & ~dif[WIDTH];

  always_comb begin
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (div) begin
      acc_nxt = {qbit ? dif[WIDTH-1:0] : rem[WIDTH-1:0],
                 acc[WIDTH-2:0], qbit};
    end
  end
`else
  logic unused_div;

  assign unused_div = div;
  assign qbit       = 1'b0;
  assign acc_nxt    = {sum, acc[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Define MDU_DIV_EN to build the divider; otherwise div ops are no-ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH);

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [1:0]         opr;
  logic               sa;
  logic               sb;
  logic               z;
  logic               unused_qbit;

  logic               sgn;
  logic               bz;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  assign sgn  = ~op[0];
  assign bz   = (b == '0);
  assign amag = (sgn && a[WIDTH-1]) ? -a : a;
  assign bmag = (sgn && b[WIDTH-1]) ? -b : b;
  assign busy = (state != IDLE);

`ifdef MDU_DIV_EN
  assign div0 = z;
`else
  assign div0 = 1'b0;
`endif

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div    (opr[1]),
    .acc    (acc),
    .opnd   (opnd),
    .acc_nxt(acc_nxt),
    .qbit   (unused_qbit)
  );

  // sa/sb are only ever set for signed ops
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (op[1] && (bz || !DIV_EN)) ? FIX : CALC;
        end
      end
      CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi   <= '0;
      lo   <= '0;
      acc  <= '0;
      cnt  <= '0;
      opnd <= '0;
      opr  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      z    <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            opr <= op;
            sa  <= sgn & a[WIDTH-1];
            sb  <= sgn & b[WIDTH-1];
            cnt <= '0;
            z   <= DIV_EN && op[1] && bz;
            if (op[1]) begin
              acc  <= bz ? {a, {WIDTH{1'b1}}}
                         : {{WIDTH{1'b0}}, amag};
              opnd <= bmag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, bmag};
              opnd <= amag;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (z) begin
            {hi, lo} <= acc;
          end else if (!opr[1]) begin
            {hi, lo} <= prod;
          end else if (DIV_EN) begin
            hi <= rmd;
            lo <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed + random checks of mdu_iter (WIDTH=32)
// against a plain-arithmetic HI/LO model.
module tb_mdu_iter;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_div0;
  int          m_lat;

  mdu_iter #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .div0 (div0),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic [1:0] o,
                         input logic [31:0] x,
                         input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    m_div0 = 1'b0;
    m_lat  = 34;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin
        p = 64'(sx * sy);
        {m_hi, m_lo} = p;
      end
      2'd1: begin
        p = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = p;
      end
      default: begin
        if (!DIV_EN) begin
          m_lat = 2;
        end else if (y == 32'd0) begin
          m_lo   = 32'hFFFF_FFFF;
          m_hi   = x;
          m_div0 = 1'b1;
          m_lat  = 2;
        end else if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          m_lo = 32'(q);
          m_hi = 32'(r);
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
    endcase
  endtask

  // Entered at a negedge; leaves at the negedge of the done cycle
  // (chain=1) or one cycle later.
  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input bit chain,
                       input bit disturb);
    int n;
    bit mt_hi;
    logic [31:0] w;
    mt_hi = hi_we;
    w = wdata;
    if (hi_we) m_hi = wdata;
    if (lo_we) m_lo = wdata;
    predict(o, x, y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_start", busy, 1);
    if (mt_hi) check("mt_with_start_hi", hi, w);
    while (!done && n < 100) begin
      if (disturb && n == 5) begin
        start = 1'b1;
        lo_we = 1'b1;
        wdata = $urandom;
        op = 2'($urandom);
      end else begin
        start = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    lo_we = 1'b0;
    check("latency", n, m_lat);
    check("busy_on_done", busy, 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("div0", div0, m_div0);
    if (!chain) begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    int seen;
    logic [1:0] ro;
    logic [31:0] rx;
    logic [31:0] ry;
    rst = 1'b1;
    start = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    m_hi = '0;
    m_lo = '0;
    m_div0 = 1'b0;
    #2 rst = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    hi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    m_hi = 32'h1234;
    check("mthi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 0);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h55AA;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    m_hi = 32'h55AA;
    m_lo = 32'h55AA;
    check("mt_both_hi", hi, 32'h55AA);
    check("mt_both_lo", lo, 32'h55AA);

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0);

    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(2'd3, 32'd100, 32'd7, 0, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(2'd2, 32'd5, 32'd0, 0, 0);
    do_op(2'd3, 32'd9, 32'd3, 0, 0);
    do_op(2'd3, 32'hDEAD_BEEF, 32'd0, 0, 0);

    hi_we = 1'b1;
    wdata = 32'hCAFE_0001;
    do_op(2'd1, 32'd3, 32'd5, 0, 0);

    do_op(2'd0, 32'd12345, 32'hFFFF_E57B, 0, 1);

    do_op(2'd1, 32'h0001_0003, 32'h0002_0005, 1, 0);
    do_op(2'd2, 32'hFFFF_FF00, 32'd0, 1, 0);
    do_op(2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    do_op(2'd2, 32'd1000, 32'hFFFF_FFF3, 0, 0);

    for (int i = 0; i < 25; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0
         : ($urandom_range(0, 1) == 1) ? 32'($urandom)
         : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) begin
        lo_we = 1'b1;
        wdata = $urandom;
      end
      do_op(ro, rx, ry, ($urandom_range(0, 1) == 1), 0);
    end

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    start = 1'b1;
    op = 2'd0;
    a = 32'h0000_7777;
    b = 32'h0000_0123;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    check("abort_hi_held", hi, 0);

    do_op(2'd0, 32'hFFFF_FF85, 32'h0000_0C35, 0, 0);
    do_op(2'd3, 32'hFFFF_FFFF, 32'd10, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
